// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// rtl/mem_bus_arbiter_pick.sv - combinational 2-way picker, round-robin or fixed priority on ties
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_fair,
  output logic [1:0] o_gnt
);

  // i_last is the index of the previous winner; a fair tie goes to the other port
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (i_fair && !i_last) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port arbiter driving a single-ported fixed-latency memory bus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int MEM_SIZE = 128,
  parameter int FAIR     = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_rw0,
  input  logic          i_rw1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdat0,
  input  logic [DW-1:0] i_wdat1,
  output logic          o_ack0,
  output logic          o_ack1,
  output logic          o_err0,
  output logic          o_err1,
  output logic [DW-1:0] o_rdat0,
  output logic [DW-1:0] o_rdat1,
  output logic          o_m_en,
  output logic          o_m_rw,
  output logic [AW-1:0] o_abus,
  output logic [DW-1:0] o_m_wdata,
  input  logic [DW-1:0] i_m_rdata,
  output logic          o_busy,
  output logic [1:0]    o_gnt
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_last;
  logic [1:0]    r_gnt;
  logic [1:0]    r_ack;
  logic [1:0]    r_err;
  logic [DW-1:0] r_rdat0;
  logic [DW-1:0] r_rdat1;
  logic          r_m_en;
  logic          r_m_rw;
  logic [AW-1:0] r_abus;
  logic [DW-1:0] r_m_wdata;

  logic [1:0]    w_pick;
  logic          w_sel1;
  logic          w_any;
  logic          w_rw;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdat;
  logic [AW:0]   w_end;
  logic          w_oor;

  rr_pick2 u_pick (
    .i_req  ({i_req1, i_req0}),
    .i_last (r_last),
    .i_fair (FAIR != 0),
    .o_gnt  (w_pick)
  );

  assign w_any  = i_req0 | i_req1;
  assign w_sel1 = w_pick[PORT_DMA];
  assign w_rw   = w_sel1 ? i_rw1   : i_rw0;
  assign w_addr = w_sel1 ? i_addr1 : i_addr0;
  assign w_wdat = w_sel1 ? i_wdat1 : i_wdat0;
  // one extra bit so a last byte that wraps past 2^AW is still out of range
  assign w_end  = {1'b0, w_addr} + (AW + 1)'(3);
  assign w_oor  = (w_end >= (AW + 1)'(MEM_SIZE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next = w_oor ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (r_cnt == 4'd0) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= 4'd0;
      r_last    <= 1'b1;
      r_gnt     <= 2'b00;
      r_ack     <= 2'b00;
      r_err     <= 2'b00;
      r_rdat0   <= '0;
      r_rdat1   <= '0;
      r_m_en    <= 1'b0;
      r_m_rw    <= RW_READ;
      r_abus    <= '0;
      r_m_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt  <= w_pick;
            r_last <= w_sel1;
            if (w_oor) begin
              r_ack <= w_pick;
              r_err <= w_pick;
              if (w_pick[PORT_CPU]) r_rdat0 <= '0;
              if (w_pick[PORT_DMA]) r_rdat1 <= '0;
            end else begin
              r_m_en    <= 1'b1;
              r_m_rw    <= w_rw;
              r_abus    <= w_addr;
              r_m_wdata <= w_wdat;
              r_cnt     <= CNT_INIT;
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_m_en <= 1'b0;
            r_ack  <= r_gnt;
            r_err  <= 2'b00;
            if (r_m_rw == RW_READ) begin
              if (r_gnt[PORT_CPU]) r_rdat0 <= i_m_rdata;
              if (r_gnt[PORT_DMA]) r_rdat1 <= i_m_rdata;
            end
          end
        end
        ST_DONE: begin
          r_ack <= 2'b00;
          r_err <= 2'b00;
          r_gnt <= 2'b00;
        end
        default: begin
          r_ack <= 2'b00;
          r_err <= 2'b00;
          r_gnt <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    o_busy = (r_state != ST_IDLE);
    o_gnt  = (r_state == ST_IDLE) ? 2'b00 : r_gnt;
  end

  assign o_ack0    = r_ack[PORT_CPU];
  assign o_ack1    = r_ack[PORT_DMA];
  assign o_err0    = r_err[PORT_CPU];
  assign o_err1    = r_err[PORT_DMA];
  assign o_rdat0   = r_rdat0;
  assign o_rdat1   = r_rdat1;
  assign o_m_en    = r_m_en;
  assign o_m_rw    = r_m_rw;
  assign o_abus    = r_abus;
  assign o_m_wdata = r_m_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench: instance 0 fair/lat 1, instance 1 fixed-priority/lat 3
module tb_mem_bus_arbiter;

  typedef struct {
    logic        err;
    logic [31:0] rdat;
  } exp_t;

  logic        clk = 1'b0;
  logic        tb_init;
  logic        rst_n   [2];
  logic        req0    [2];
  logic        req1    [2];
  logic        rw0     [2];
  logic        rw1     [2];
  logic [31:0] addr0   [2];
  logic [31:0] addr1   [2];
  logic [31:0] wdat0   [2];
  logic [31:0] wdat1   [2];
  wire         ack0    [2];
  wire         ack1    [2];
  wire         err0    [2];
  wire         err1    [2];
  wire  [31:0] rdat0   [2];
  wire  [31:0] rdat1   [2];
  wire         m_en    [2];
  wire         m_rw    [2];
  wire  [31:0] abus    [2];
  wire  [31:0] m_wdata [2];
  wire  [31:0] m_rdata [2];
  wire         busy    [2];
  wire  [1:0]  gnt     [2];
  logic [31:0] mem     [2][32];

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q    [4][$];
  int          ord_q    [2][$];
  logic [31:0] exp_last [4];
  int          en_cnt   [2];
  logic [31:0] en_abus  [2];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MEM_SIZE(128), .FAIR(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n[0]),
    .i_req0(req0[0]), .i_req1(req1[0]), .i_rw0(rw0[0]), .i_rw1(rw1[0]),
    .i_addr0(addr0[0]), .i_addr1(addr1[0]), .i_wdat0(wdat0[0]), .i_wdat1(wdat1[0]),
    .o_ack0(ack0[0]), .o_ack1(ack1[0]), .o_err0(err0[0]), .o_err1(err1[0]),
    .o_rdat0(rdat0[0]), .o_rdat1(rdat1[0]),
    .o_m_en(m_en[0]), .o_m_rw(m_rw[0]), .o_abus(abus[0]), .o_m_wdata(m_wdata[0]),
    .i_m_rdata(m_rdata[0]), .o_busy(busy[0]), .o_gnt(gnt[0])
  );

  mem_bus_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MEM_SIZE(128), .FAIR(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n[1]),
    .i_req0(req0[1]), .i_req1(req1[1]), .i_rw0(rw0[1]), .i_rw1(rw1[1]),
    .i_addr0(addr0[1]), .i_addr1(addr1[1]), .i_wdat0(wdat0[1]), .i_wdat1(wdat1[1]),
    .o_ack0(ack0[1]), .o_ack1(ack1[1]), .o_err0(err0[1]), .o_err1(err1[1]),
    .o_rdat0(rdat0[1]), .o_rdat1(rdat1[1]),
    .o_m_en(m_en[1]), .o_m_rw(m_rw[1]), .o_abus(abus[1]), .o_m_wdata(m_wdata[1]),
    .i_m_rdata(m_rdata[1]), .o_busy(busy[1]), .o_gnt(gnt[1])
  );

  function automatic logic [31:0] pat(int w);
    return (w == 6) ? 32'h0 : (32'hC0DE_0000 + 32'(w));
  endfunction

  assign m_rdata[0] = mem[0][abus[0][6:2]];
  assign m_rdata[1] = mem[1][abus[1][6:2]];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (tb_init) begin
        for (int w = 0; w < 32; w++) mem[d][w] <= pat(w);
      end else if (m_en[d] && !m_rw[d]) begin
        mem[d][abus[d][6:2]] <= m_wdata[d];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ack(int d, int p);
    return (p == 0) ? ack0[d] : ack1[d];
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d]) begin
        if (m_en[d]) begin
          en_cnt[d]++;
          en_abus[d] = abus[d];
        end
        if (ack0[d] || ack1[d]) begin
          int   p;
          int   k;
          exp_t e;
          p = ack1[d] ? 1 : 0;
          k = d * 2 + p;
          check_val("dual_ack", 32'(ack0[d] & ack1[d]), 32'd0);
          check_val("gnt_at_ack", 32'(gnt[d]), (p == 1) ? 32'd2 : 32'd1);
          check_val("sb_nonempty", 32'(exp_q[k].size() != 0), 32'd1);
          if (exp_q[k].size() != 0) begin
            e = exp_q[k].pop_front();
            check_val("err", 32'((p == 0) ? err0[d] : err1[d]), 32'(e.err));
            check_val("rdat", (p == 0) ? rdat0[d] : rdat1[d], e.rdat);
          end
          if (ord_q[d].size() != 0) begin
            check_val("grant_order", 32'(p), 32'(ord_q[d].pop_front()));
          end
        end
      end
    end
  end

  // called at a negedge; returns one negedge after the ack so DONE has drained
  task automatic access(input int d, input int p, input logic rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_lat);
    exp_t e;
    int   k;
    int   n;
    logic seen;
    k = d * 2 + p;
    n = 0;
    seen = 1'b0;
    e.err  = exp_err;
    e.rdat = exp_err ? 32'h0 : (rd ? exp_rd : exp_last[k]);
    exp_last[k] = e.rdat;
    exp_q[k].push_back(e);
    if (p == 0) begin
      rw0[d] = rd; addr0[d] = a; wdat0[d] = wd; req0[d] = 1'b1;
    end else begin
      rw1[d] = rd; addr1[d] = a; wdat1[d] = wd; req1[d] = 1'b1;
    end
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      seen = get_ack(d, p);
    end
    check_val("ack_seen", 32'(seen), 32'd1);
    if (exp_lat > 0) check_val("latency", 32'(n), 32'(exp_lat));
    if (p == 0) req0[d] = 1'b0;
    else        req1[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset(input int d);
    check_val("rst_m_en",    32'(m_en[d]),  32'd0);
    check_val("rst_m_rw",    32'(m_rw[d]),  32'd1);
    check_val("rst_abus",    abus[d],       32'd0);
    check_val("rst_m_wdata", m_wdata[d],    32'd0);
    check_val("rst_ack0",    32'(ack0[d]),  32'd0);
    check_val("rst_ack1",    32'(ack1[d]),  32'd0);
    check_val("rst_err0",    32'(err0[d]),  32'd0);
    check_val("rst_err1",    32'(err1[d]),  32'd0);
    check_val("rst_rdat0",   rdat0[d],      32'd0);
    check_val("rst_rdat1",   rdat1[d],      32'd0);
    check_val("rst_busy",    32'(busy[d]),  32'd0);
    check_val("rst_gnt",     32'(gnt[d]),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tb_init = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req0[d] = 1'b0; req1[d] = 1'b0; rw0[d] = 1'b1; rw1[d] = 1'b1;
      addr0[d] = '0; addr1[d] = '0; wdat0[d] = '0; wdat1[d] = '0;
      en_cnt[d] = 0; en_abus[d] = '0;
    end
    for (int k = 0; k < 4; k++) exp_last[k] = '0;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    tb_init  = 1'b0;

    // simultaneous request streams straight out of reset on both instances
    foreach (ord_q[0][i]) ord_q[0].delete(i);
    ord_q[0] = '{0, 1, 0, 1, 0, 1};
    ord_q[1] = '{0, 0, 0, 1, 1, 1};
    fork
      for (int i = 0; i < 3; i++) access(0, 0, 1'b1, 32'(4 * i), 32'h0, 1'b0, pat(i), 0);
      for (int i = 0; i < 3; i++) access(0, 1, 1'b1, 32'h40 + 32'(4 * i), 32'h0, 1'b0, pat(16 + i), 0);
      for (int i = 0; i < 3; i++) access(1, 0, 1'b1, 32'(4 * i), 32'h0, 1'b0, pat(i), 0);
      for (int i = 0; i < 3; i++) access(1, 1, 1'b1, 32'h40 + 32'(4 * i), 32'h0, 1'b0, pat(16 + i), 0);
    join
    check_val("order_drained_a", 32'(ord_q[0].size()), 32'd0);
    check_val("order_drained_b", 32'(ord_q[1].size()), 32'd0);

    en_cnt[0] = 0;
    access(0, 0, 1'b1, 32'h18, 32'h0, 1'b0, 32'h0, 2);
    check_val("single_read_en_cycles", 32'(en_cnt[0]), 32'd1);
    check_val("single_read_abus", en_abus[0], 32'h18);

    access(0, 1, 1'b0, 32'h20, 32'h0000_002A, 1'b0, 32'h0, 2);
    access(0, 1, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0000_002A, 2);

    en_cnt[0] = 0;
    access(0, 0, 1'b1, 32'h7E, 32'h0, 1'b1, 32'h0, 1);
    access(0, 0, 1'b1, 32'h7C, 32'h0, 1'b0, pat(31), 2);
    access(0, 1, 1'b1, 32'h7D, 32'h0, 1'b1, 32'h0, 1);
    access(0, 1, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b1, 32'h0, 1);
    check_val("range_en_cycles", 32'(en_cnt[0]), 32'd1);

    // reset in the second ACCESS cycle aborts the access without an ack
    rw0[1] = 1'b1; addr0[1] = 32'h08; req0[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("abort_m_en_before", 32'(m_en[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    check_reset(1);
    req0[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    access(1, 0, 1'b1, 32'h0C, 32'h0, 1'b0, pat(3), 4);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) check_val("sb_drained", 32'(exp_q[k].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
